hidden_delta_accum: RTL and testbench

Multi-channel backpropagation unit that computes the hidden-layer error term for NCH hidden neurons in parallel. For each neuron it forms the dot product of that neuron's outgoing weights with the output-layer deltas, streamed one output neuron per beat. It then applies the ReLU derivative mask, rescales, and saturates the result. It sits between the output-delta stage and the hidden-weight update stage of the training datapath, and generalises the single-neuron, single-beat derivative block to NOUT serial terms with valid/ready handshakes.

---
 rtl/hidden_delta_pkg.sv | 36 +++
 rtl/hidden_delta_lane.sv | 62 ++++++
 rtl/hidden_delta_accum.sv | 114 +++++++++++
 tb/tb_hidden_delta_accum.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hidden_delta_pkg.sv
// Shared types and helpers for the hidden-layer delta accumulator: FSM state
// encoding, accumulator width derivation and the result saturation function.
package hidden_delta_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    SCALE  = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // One guard bit per doubling of NOUT plus one for the most-negative product.
  function automatic int acc_bits(input int nw, input int nd, input int nout);
    return nw + nd + clog2(nout) + 1;
  endfunction

  // Clamp a sign-extended accumulator value into an obits-wide signed range.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                   input int obits);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (obits - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (obits - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/hidden_delta_lane.sv
// One hidden-neuron lane: signed MAC accumulator, ReLU-derivative mask and
// shift/saturate into a registered result. HIDDEN_DELTA_ROUND_EN selects round-half-up.
module hidden_delta_lane
  import hidden_delta_pkg::*;
#(
  parameter int NWBITS  = 16,
  parameter int NDBITS  = 16,
  parameter int ACCBITS = 37,
  parameter int OBITS   = 17
) (
  input  logic                     clk,
  input  logic                     reset_b,
  input  logic                     clear,
  input  logic                     acc_en,
  input  logic                     scale_en,
  input  logic                     mask,
  input  logic signed [NWBITS-1:0] weight,
  input  logic signed [NDBITS-1:0] delta,
  output logic signed [OBITS-1:0]  result
);

  localparam int PBITS = NWBITS + NDBITS;

`ifdef HIDDEN_DELTA_ROUND_EN
  localparam logic signed [ACCBITS:0] ROUND_K = (ACCBITS + 1)'(64'd1 << (NDBITS - 2));
`else
  localparam logic signed [ACCBITS:0] ROUND_K = '0;
`endif

  logic signed [PBITS-1:0]   prod;
  logic signed [ACCBITS-1:0] acc;
  logic signed [ACCBITS:0]   pre;
  logic signed [ACCBITS:0]   shifted;
  logic signed [OBITS-1:0]   sat_r;

  // Full PBITS product: even (-2^(NW-1)) * (-2^(ND-1)) fits without wrap.
  assign prod = PBITS'(weight) * PBITS'(delta);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (acc_en) begin
      acc <= acc + ACCBITS'(prod);
    end
  end

  // One extra bit keeps the rounding add from wrapping near the positive limit.
  assign pre     = (ACCBITS + 1)'(acc) + ROUND_K;
  assign shifted = pre >>> (NDBITS - 1);
  assign sat_r   = OBITS'(saturate(64'(shifted), OBITS));

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      result <= '0;
    end else if (scale_en) begin
      result <= mask ? '0 : sat_r;
    end
  end

endmodule

// File: rtl/hidden_delta_accum.sv
// Hidden-layer error term for NCH neurons: streams NOUT weight/delta beats,
// then masks, rescales and saturates. Build option: HIDDEN_DELTA_ROUND_EN.
module hidden_delta_accum
  import hidden_delta_pkg::*;
#(
  parameter int NWBITS = 16,
  parameter int NDBITS = 16,
  parameter int NCH    = 4,
  parameter int NOUT   = 10,
  parameter int OBITS  = NWBITS + 1
) (
  input  logic                    clk,
  input  logic                    reset_b,
  input  logic                    start,
  input  logic [NCH-1:0]          isneg,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NCH*NWBITS-1:0]   weight_vec,
  input  logic [NDBITS-1:0]       delta,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NCH*OBITS-1:0]    deriv_vec,
  output logic                    busy,
  output logic [1:0]              dbg_state
);

  localparam int ACCBITS = acc_bits(NWBITS, NDBITS, NOUT);
  localparam int CNTW    = (NOUT > 1) ? clog2(NOUT) : 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(NOUT - 1);

  state_t          state;
  state_t          state_nxt;
  logic [CNTW-1:0] cnt;
  logic [NCH-1:0]  mask_q;
  logic            clear;
  logic            acc_en;
  logic            scale_en;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state <= IDLE;
    else          state <= state_nxt;
  end

  // Handshakes: a beat transfers on a rising edge where in_valid && in_ready,
  // a result on one where out_valid && out_ready; valid never waits on ready.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    clear     = 1'b0;
    acc_en    = 1'b0;
    scale_en  = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          clear     = 1'b1;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_en = 1'b1;
          if (cnt == LAST) state_nxt = SCALE;
        end
      end
      SCALE: begin
        scale_en  = 1'b1;
        state_nxt = OUTPUT;
      end
      OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      cnt    <= '0;
      mask_q <= '0;
    end else if (clear) begin
      cnt    <= '0;
      mask_q <= isneg;
    end else if (acc_en) begin
      cnt <= cnt + CNTW'(1);
    end
  end

  assign dbg_state = state;

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    hidden_delta_lane #(
      .NWBITS  (NWBITS),
      .NDBITS  (NDBITS),
      .ACCBITS (ACCBITS),
      .OBITS   (OBITS)
    ) u_lane (
      .clk      (clk),
      .reset_b  (reset_b),
      .clear    (clear),
      .acc_en   (acc_en),
      .scale_en (scale_en),
      .mask     (mask_q[c]),
      .weight   (weight_vec[c*NWBITS +: NWBITS]),
      .delta    (delta),
      .result   (deriv_vec[c*OBITS +: OBITS])
    );
  end

endmodule

// File: tb/tb_hidden_delta_accum.sv
// Bench for hidden_delta_accum (NCH=4, NOUT=3): randomized jobs against a
// plain-arithmetic reference model, plus directed mask/saturation/rounding cases.
module tb_hidden_delta_accum;

  localparam int NW   = 16;
  localparam int ND   = 16;
  localparam int NCH  = 4;
  localparam int NOUT = 3;
  localparam int OB   = NW + 1;
  localparam int VW   = NCH * OB;
  localparam int CYC_LIMIT = 200;

  logic                 clk;
  logic                 reset_b;
  logic                 start;
  logic [NCH-1:0]       isneg;
  logic                 in_valid;
  logic                 in_ready;
  logic [NCH*NW-1:0]    weight_vec;
  logic [ND-1:0]        delta;
  logic                 out_valid;
  logic                 out_ready;
  logic [VW-1:0]        deriv_vec;
  logic                 busy;
  logic [1:0]           dbg_state;

  hidden_delta_accum #(
    .NWBITS (NW),
    .NDBITS (ND),
    .NCH    (NCH),
    .NOUT   (NOUT),
    .OBITS  (OB)
  ) dut (
    .clk        (clk),
    .reset_b    (reset_b),
    .start      (start),
    .isneg      (isneg),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .weight_vec (weight_vec),
    .delta      (delta),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .deriv_vec  (deriv_vec),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            w_tab [NOUT][NCH];
  int            d_tab [NOUT];
  logic [VW-1:0] exp_q [$];
  int            n_checks = 0;
  int            n_pass   = 0;
  bit            bp_pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  // reference model: exact dot product, then mask / floor-scale / clamp
  function automatic logic [VW-1:0] model(input logic [NCH-1:0] m);
    logic [VW-1:0] r;
    longint s;
    longint q;
    r = '0;
    for (int c = 0; c < NCH; c++) begin
      s = 0;
      for (int k = 0; k < NOUT; k++) s += longint'(w_tab[k][c]) * longint'(d_tab[k]);
      if (m[c]) begin
        q = 0;
      end else begin
`ifdef HIDDEN_DELTA_ROUND_EN
        s += 16384;
`endif
        q = s / 32768;
        if ((s % 32768 != 0) && (s < 0)) q -= 1;
        if (q > 65535)  q = 65535;
        if (q < -65536) q = -65536;
      end
      r[c*OB +: OB] = q[OB-1:0];
    end
    return r;
  endfunction

  function automatic int rand_s16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic fill_random();
    for (int k = 0; k < NOUT; k++) begin
      for (int c = 0; c < NCH; c++) w_tab[k][c] = rand_s16();
      d_tab[k] = rand_s16();
    end
  endtask

  task automatic fill_const(input int w0, input int w1, input int w2, input int w3, input int d);
    for (int k = 0; k < NOUT; k++) begin
      w_tab[k][0] = w0; w_tab[k][1] = w1; w_tab[k][2] = w2; w_tab[k][3] = w3;
      d_tab[k] = d;
    end
  endtask

  // driver: put beat k on the bus
  task automatic set_beat(input int k);
    int t;
    for (int c = 0; c < NCH; c++) begin
      t = w_tab[k][c];
      weight_vec[c*NW +: NW] = t[NW-1:0];
    end
    t = d_tab[k];
    delta = t[ND-1:0];
  endtask

  // driver: one full job; reports latency (cycles from start to out_valid)
  task automatic drive_job(input logic [NCH-1:0] m, input int stall_mode, input int hold,
                           input bit noise, input bit b2b, output int lat,
                           output logic [VW-1:0] got, output bit stable, output bit tmo);
    int  k;
    int  cyc;
    int  it;
    bit  go;
    stable = 1'b1;
    if (!b2b) @(negedge clk);
    start = 1'b1; isneg = m; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0; isneg = NCH'($urandom);
    cyc = 1; k = 0; it = 0;
    while (k < NOUT && cyc < CYC_LIMIT) begin
      case (stall_mode)
        0:       go = 1'b1;
        1:       go = (it < 5) ? bp_pat[it] : 1'b1;
        default: go = ($urandom_range(0, 2) != 0);
      endcase
      in_valid = go;
      if (go) set_beat(k);
      else begin
        weight_vec = {$urandom, $urandom};
        delta      = ND'($urandom);
      end
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        isneg = NCH'($urandom);
      end
      if (go && in_ready) k++;
      @(negedge clk);
      cyc++; it++;
    end
    in_valid = 1'b0; start = 1'b0;
    while (!out_valid && cyc < CYC_LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    tmo = !out_valid;
    lat = cyc;
    got = deriv_vec;
    for (int h = 0; h < hold; h++) begin
      if (noise) start = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (!out_valid || deriv_vec !== got) stable = 1'b0;
    end
    start = noise;
    isneg = NCH'($urandom);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_b = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else n_pass++;
    n_checks++; if (deriv_vec !== '0) $display("FAIL reset_deriv got=%h exp=0", deriv_vec); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    reset_b = 1'b1;
    in_valid = 1'b1;
    weight_vec = {$urandom, $urandom};
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b0 || busy !== 1'b0) $display("FAIL idle_ignores_beat in_ready=%b busy=%b exp=0/0", in_ready, busy); else n_pass++;
    in_valid = 1'b0;
  endtask

  task automatic test_basic();
    int lat; logic [VW-1:0] got; logic [VW-1:0] e; bit st; bit tmo;
    fill_const(100, -50, 0, 7, 16384);
    exp_q.push_back(model(4'b0000));
    drive_job(4'b0000, 0, 0, 1'b0, 1'b0, lat, got, st, tmo);
    e = exp_q.pop_front();
    n_checks++; if (tmo || got !== e) $display("FAIL basic_deriv got=%h exp=%h", got, e); else n_pass++;
    n_checks++; if ($signed(got[0*OB +: OB]) !== 150) $display("FAIL basic_ch0 got=%0d exp=150", $signed(got[0 +: OB])); else n_pass++;
    n_checks++; if ($signed(got[1*OB +: OB]) !== -75) $display("FAIL basic_ch1 got=%0d exp=-75", $signed(got[OB +: OB])); else n_pass++;
    n_checks++; if (lat !== NOUT + 2) $display("FAIL basic_latency got=%0d exp=%0d", lat, NOUT + 2); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL basic_idle_after got=%b exp=0", busy); else n_pass++;
  endtask

  task automatic test_mask();
    int lat; logic [VW-1:0] got; logic [VW-1:0] e; bit st; bit tmo;
    fill_const(100, -50, 0, 7, 16384);
    exp_q.push_back(model(4'b0101));
    drive_job(4'b0101, 0, 0, 1'b0, 1'b0, lat, got, st, tmo);
    e = exp_q.pop_front();
    n_checks++; if (tmo || got !== e) $display("FAIL mask_deriv got=%h exp=%h", got, e); else n_pass++;
    n_checks++; if (got[0 +: OB] !== '0) $display("FAIL mask_ch0 got=%h exp=0", got[0 +: OB]); else n_pass++;
    n_checks++; if ($signed(got[1*OB +: OB]) !== -75) $display("FAIL mask_ch1 got=%0d exp=-75", $signed(got[OB +: OB])); else n_pass++;
  endtask

  task automatic test_saturation();
    int lat; logic [VW-1:0] got; logic [VW-1:0] e; bit st; bit tmo;
    fill_const(-32768, -32768, -32768, -32768, -32768);
    exp_q.push_back(model(4'b0000));
    drive_job(4'b0000, 0, 0, 1'b0, 1'b0, lat, got, st, tmo);
    e = exp_q.pop_front();
    n_checks++; if (tmo || got !== e) $display("FAIL sat_deriv got=%h exp=%h", got, e); else n_pass++;
    for (int c = 0; c < NCH; c++) begin
      n_checks++;
      if ($signed(got[c*OB +: OB]) !== 65535) $display("FAIL sat_ch%0d got=%0d exp=65535", c, $signed(got[c*OB +: OB]));
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [VW-1:0] got; logic [VW-1:0] e; bit st; bit tmo;
    fill_const(100, -50, 0, 7, 16384);
    exp_q.push_back(model(4'b0000));
    drive_job(4'b0000, 1, 4, 1'b0, 1'b0, lat, got, st, tmo);
    e = exp_q.pop_front();
    n_checks++; if (tmo || got !== e) $display("FAIL bp_deriv got=%h exp=%h", got, e); else n_pass++;
    n_checks++; if (st !== 1'b1) $display("FAIL bp_hold_stable got=%b exp=1", st); else n_pass++;
    n_checks++; if (lat !== NOUT + 4) $display("FAIL bp_latency got=%0d exp=%0d", lat, NOUT + 4); else n_pass++;
  endtask

  task automatic test_rounding();
    int lat; logic [VW-1:0] got; logic [VW-1:0] e; bit st; bit tmo;
    int e0; int e1;
    fill_const(0, 0, 0, 0, 0);
    w_tab[0][0] = 3; w_tab[0][1] = -3; w_tab[0][2] = 3; w_tab[0][3] = -3;
    d_tab[0] = 16384;
`ifdef HIDDEN_DELTA_ROUND_EN
    e0 = 2; e1 = -1;
`else
    e0 = 1; e1 = -2;
`endif
    exp_q.push_back(model(4'b0000));
    drive_job(4'b0000, 0, 0, 1'b0, 1'b0, lat, got, st, tmo);
    e = exp_q.pop_front();
    n_checks++; if (tmo || got !== e) $display("FAIL round_deriv got=%h exp=%h", got, e); else n_pass++;
    n_checks++; if ($signed(got[0 +: OB]) !== e0) $display("FAIL round_pos got=%0d exp=%0d", $signed(got[0 +: OB]), e0); else n_pass++;
    n_checks++; if ($signed(got[OB +: OB]) !== e1) $display("FAIL round_neg got=%0d exp=%0d", $signed(got[OB +: OB]), e1); else n_pass++;
  endtask

  task automatic test_reset_mid_job();
    int lat; logic [VW-1:0] got; logic [VW-1:0] e; bit st; bit tmo;
    fill_random();
    @(negedge clk);
    start = 1'b1; isneg = '0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      set_beat(k);
      @(negedge clk);
    end
    in_valid = 1'b0;
    reset_b = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || in_ready !== 1'b0) $display("FAIL midrst_state busy=%b in_ready=%b exp=0/0", busy, in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0 || deriv_vec !== '0) $display("FAIL midrst_out out_valid=%b deriv=%h exp=0/0", out_valid, deriv_vec); else n_pass++;
    reset_b = 1'b1;
    fill_random();
    exp_q.push_back(model(4'b0010));
    drive_job(4'b0010, 0, 0, 1'b0, 1'b0, lat, got, st, tmo);
    e = exp_q.pop_front();
    n_checks++; if (tmo || got !== e) $display("FAIL midrst_fresh got=%h exp=%h", got, e); else n_pass++;
  endtask

  task automatic test_start_while_busy();
    int lat; logic [VW-1:0] got; logic [VW-1:0] e; bit st; bit tmo;
    fill_random();
    exp_q.push_back(model(4'b1001));
    drive_job(4'b1001, 2, 3, 1'b1, 1'b0, lat, got, st, tmo);
    e = exp_q.pop_front();
    n_checks++; if (tmo || got !== e) $display("FAIL busy_start_deriv got=%h exp=%h", got, e); else n_pass++;
    n_checks++; if (st !== 1'b1) $display("FAIL busy_start_stable got=%b exp=1", st); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL start_at_handshake busy=%b exp=0", busy); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat; logic [VW-1:0] got; logic [VW-1:0] e; bit st; bit tmo;
    for (int j = 0; j < 2; j++) begin
      fill_random();
      exp_q.push_back(model(4'b0000));
      drive_job(4'b0000, 0, 0, 1'b0, (j == 1), lat, got, st, tmo);
      e = exp_q.pop_front();
      n_checks++; if (tmo || got !== e) $display("FAIL b2b_deriv job=%0d got=%h exp=%h", j, got, e); else n_pass++;
      n_checks++; if (lat !== NOUT + 2) $display("FAIL b2b_latency job=%0d got=%0d exp=%0d", j, lat, NOUT + 2); else n_pass++;
    end
  endtask

  task automatic test_random();
    int lat; logic [VW-1:0] got; logic [VW-1:0] e; bit st; bit tmo;
    logic [NCH-1:0] m;
    for (int j = 0; j < 10; j++) begin
      fill_random();
      if (j % 4 == 0) begin
        for (int k = 0; k < NOUT; k++) begin
          w_tab[k][j % NCH] = ($urandom_range(0, 1) != 0) ? -32768 : 32767;
          d_tab[k] = -32768;
        end
      end
      m = NCH'($urandom);
      exp_q.push_back(model(m));
      drive_job(m, 2, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0, lat, got, st, tmo);
      e = exp_q.pop_front();
      n_checks++; if (tmo || got !== e || st !== 1'b1) $display("FAIL random_job%0d got=%h exp=%h stable=%b", j, got, e, st); else n_pass++;
    end
  endtask

  initial begin
    reset_b = 1'b0; start = 1'b0; isneg = '0; in_valid = 1'b0;
    weight_vec = '0; delta = '0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_mask();
    test_saturation();
    test_backpressure();
    test_rounding();
    test_reset_mid_job();
    test_start_while_busy();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

endmodule
